// File: rtl/pwm_capture.sv
// pwm_capture: measures period and high time of an external PWM signal in
// prescaled ticks, reports each completed period with a one-cycle Valid
// strobe, and flags a stuck input through a sticky Overflow timeout.
module pwm_capture #(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             CLK,
  input  logic             _RST,
  input  logic             Enable,
  input  logic [WIDTH-1:0] Prescaler,
  input  logic             PWMIn,
  output logic [WIDTH-1:0] Period,
  output logic [WIDTH-1:0] HighTime,
  output logic             Valid,
  output logic             Overflow,
  output logic             Level
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HIGH = 2'd1,
    S_LOW  = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH:0]   PCNT_ONE = {{WIDTH{1'b0}}, 1'b1};

  // Synchronizer and edge detection
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   sync_w;
  logic                   rise_w;
  logic                   fall_w;

  // Prescaler
  logic [WIDTH:0]   pcnt_q;
  logic [WIDTH:0]   pcnt_d;
  logic [WIDTH:0]   lim_w;
  logic             tick_w;

  // Measurement engine
  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;
  logic [WIDTH-1:0] hl_q;
  logic [WIDTH-1:0] hl_d;
  logic [WIDTH-1:0] period_q;
  logic [WIDTH-1:0] period_d;
  logic [WIDTH-1:0] hightime_q;
  logic [WIDTH-1:0] hightime_d;
  logic             valid_q;
  logic             valid_d;
  logic             ovf_q;
  logic             ovf_d;

  logic [WIDTH-1:0] cnt_plus_w;
  logic [WIDTH-1:0] restart_w;
  logic             timeout_w;

  // Input synchronizer plus previous-value register; keeps tracking PWMIn
  // even while the capture engine is disabled so Level stays live.
  always_ff @(posedge CLK) begin
    if (!_RST) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], PWMIn};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign sync_w = sync_q[SYNC_STAGES-1];
  assign rise_w = sync_w & ~prev_q;
  assign fall_w = ~sync_w & prev_q;
  assign Level  = sync_w;

  // The limit is one bit wider than Prescaler so an all-ones Prescaler gives
  // a tick every 2^WIDTH+1 cycles instead of wrapping to zero. pcnt is also
  // one bit wider because it must be able to reach that limit.
  assign lim_w  = {1'b0, Prescaler} + PCNT_ONE;
  assign tick_w = Enable & (pcnt_q >= lim_w);

  // Prescaler next state: free-runs while enabled, cleared otherwise.
  always_comb begin
    pcnt_d = pcnt_q + PCNT_ONE;
    if (!Enable || tick_w) begin
      pcnt_d = '0;
    end
  end

  // Prescaler counter register.
  always_ff @(posedge CLK) begin
    if (!_RST) begin
      pcnt_q <= '0;
    end else begin
      pcnt_q <= pcnt_d;
    end
  end

  // A tick landing in the same cycle as an edge is credited to the phase
  // that is ending, and also starts the new measurement at 1.
  assign cnt_plus_w = cnt_q + {{(WIDTH-1){1'b0}}, tick_w};
  assign restart_w  = {{(WIDTH-1){1'b0}}, tick_w};
  assign timeout_w  = tick_w & (cnt_q == CNT_MAX);

  // Next-state and result logic for the measurement FSM.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    hl_d       = hl_q;
    period_d   = period_q;
    hightime_d = hightime_q;
    valid_d    = 1'b0;
    ovf_d      = ovf_q;

    if (tick_w) begin
      cnt_d = cnt_q + CNT_ONE;
    end

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (rise_w) begin
          state_d = S_HIGH;
          cnt_d   = restart_w;
        end
      end
      S_HIGH: begin
        // Timeout wins over an edge: cnt cannot represent one more tick.
        if (timeout_w) begin
          ovf_d   = 1'b1;
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (fall_w) begin
          hl_d    = cnt_plus_w;
          state_d = S_LOW;
        end
      end
      S_LOW: begin
        if (timeout_w) begin
          ovf_d   = 1'b1;
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (rise_w) begin
          period_d   = cnt_plus_w;
          hightime_d = hl_q;
          valid_d    = 1'b1;
          ovf_d      = 1'b0;
          state_d    = S_HIGH;
          cnt_d      = restart_w;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Disable clears the engine but leaves the last results visible.
    if (!Enable) begin
      state_d    = S_IDLE;
      cnt_d      = '0;
      hl_d       = '0;
      period_d   = period_q;
      hightime_d = hightime_q;
      valid_d    = 1'b0;
      ovf_d      = ovf_q;
    end
  end

  // Measurement FSM state, counters and result registers.
  always_ff @(posedge CLK) begin
    if (!_RST) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      hl_q       <= '0;
      period_q   <= '0;
      hightime_q <= '0;
      valid_q    <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hl_q       <= hl_d;
      period_q   <= period_d;
      hightime_q <= hightime_d;
      valid_q    <= valid_d;
      ovf_q      <= ovf_d;
    end
  end

  assign Period   = period_q;
  assign HighTime = hightime_q;
  assign Valid    = valid_q;
  assign Overflow = ovf_q;

endmodule

// File: doc/pwm_capture.md
Name: pwm_capture

Overview:
- Measures an incoming PWM waveform: period and high time, in prescaled ticks.
- Counterpart of the PWM timer output. Used on IO-expander input pins to read back external PWM, or to loop-check our own timer channels.
- Reports each completed period with a one-cycle Valid strobe.
- Flags stuck-level (0%/100% duty) inputs through a saturation timeout.

Parameters:
- WIDTH, 16, width of prescaler, counters and result registers.
- SYNC_STAGES, 2, number of flip-flops in the PWMIn input synchronizer (minimum 2).

Ports:
- CLK  input  1  system clock; all logic on the rising edge.
- _RST  input  1  synchronous, active-low reset.
- Enable  input  1  1 = capture running; 0 = synchronous clear of the capture engine.
- Prescaler  input  WIDTH  tick divider; one tick every Prescaler+2 CLK cycles.
- PWMIn  input  1  asynchronous PWM input.
- Period  output  WIDTH  ticks from one rising edge to the next, last completed period.
- HighTime  output  WIDTH  ticks from that rising edge to the following falling edge.
- Valid  output  1  one-CLK pulse when Period/HighTime update.
- Overflow  output  1  sticky timeout flag: no edge seen for 2^WIDTH-1 ticks.
- Level  output  1  synchronized PWMIn level.

Behaviour:
- Reset (_RST=0 at a CLK edge):
  - Period=0, HighTime=0, Valid=0, Overflow=0, Level=0.
  - Synchronizer and edge register cleared; state=IDLE; all counters 0.
- Synchronizer and edge detection:
  - SYNC_STAGES-FF synchronizer, then one previous-value register.
  - rise = sync & ~prev; fall = ~sync & prev. Both are combinational within the cycle.
  - Level = synchronizer output.
- Prescaler:
  - pcnt free-runs while Enable=1.
  - When pcnt >= Prescaler+1: tick=1 that cycle and pcnt<=0. Otherwise pcnt<=pcnt+1.
  - Prescaler+1 is computed at WIDTH+1 bits, so Prescaler=0xFFFF does not wrap.
  - A Prescaler change takes effect immediately. A decrease below pcnt gives a tick on the next cycle.
- Tick counter cnt:
  - Increments on tick.
  - On a restart (rise in IDLE or LOW), cnt <= tick ? 1 : 0, so no tick is lost.
- State machine:
  - IDLE: cnt held 0. On rise -> HIGH, cnt restarts.
  - HIGH: on fall, hl<=cnt (internal high-time latch, including a tick in the same cycle) -> LOW.
  - LOW: on rise:
    - Period<=cnt (+1 if tick this cycle), HighTime<=hl, Valid<=1, Overflow<=0.
    - Then -> HIGH, cnt restarts.
  - HIGH or LOW with cnt==2^WIDTH-1 and tick: Overflow<=1 -> IDLE; no Valid is produced.
  - Period/HighTime keep their previous values on overflow.
  - The first rise after reset, enable or overflow only starts a measurement; it never produces Valid.
- Latency: Valid and new results appear on the (SYNC_STAGES+1)th CLK edge, counted from and including the edge that first samples PWMIn high.
- Valid is high for exactly 1 CLK and is otherwise 0.
- Enable=0, synchronous:
  - state=IDLE; cnt, pcnt and hl = 0; Valid=0.
  - Period, HighTime and Overflow hold their values.
  - Synchronizer and Level keep tracking PWMIn.
- Reset mid-measurement: discards the partial period; everything goes to reset values.
- Minimum measurable high or low phase: 1 CLK after synchronization. Shorter pulses may be lost.
- HighTime=0 is legal (high phase shorter than 1 tick).
- Accuracy: each result is ±1 tick.

Test Plan:
- Basic capture:
  - Stimulus: Prescaler=0, Enable=1, PWMIn 20 CLK high / 30 CLK low, repeated 4 times.
  - Response: no Valid on the first rise; then Valid every 50 CLK with Period=25±1, HighTime=10±1, Overflow=0.
- Valid timing:
  - Stimulus: Prescaler=3, PWMIn 40 high / 40 low, SYNC_STAGES=2.
  - Response: Valid on the 3rd CLK edge after PWMIn is sampled high; Period=16±1, HighTime=8±1; Valid exactly 1 CLK wide.
- Stuck high:
  - Stimulus: WIDTH=8, Prescaler=0, PWMIn held 1 after one valid period.
  - Response: Overflow=1 after 255 ticks (about 510 CLK), no Valid, Level=1, Period/HighTime unchanged.
  - Then resume a 10/10 CLK PWM: the first rise gives no Valid; the second rise gives Valid, Period=10±1, HighTime=5±1, Overflow cleared.
- Enable mid-run:
  - Stimulus: drop Enable for 5 CLK mid-high-phase, then re-raise it.
  - Response: no Valid for the interrupted period; old Period held; first rise after re-enable gives no Valid, second rise gives a correct result.
- Reset:
  - Stimulus: assert _RST=0 for 1 CLK during LOW.
  - Response: next edge gives all outputs 0 and state IDLE; _RST low while CLK toggles has effect only at CLK edges.
- Prescaler=0xFFFF:
  - Stimulus: 200000 CLK high / 200000 low.
  - Response: Period=6±1, HighTime=3±1 (tick = 65537 CLK); no wrap of Prescaler+1.
